image_row_feeder: RTL and testbench

Upstream front end for `simpleCNN`. It accepts a byte-wide pixel stream with a valid/ready handshake and packs each image row into one wide word. It drives the classifier's `START`, `X`, `Y` and `IMGIN` inputs with one `START` pulse and then one row per transfer. It holds off the next image until the classifier's `DONE`.

---
 rtl/image_row_feeder.sv | 114 +++++++++++
 tb/tb_image_row_feeder.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_row_feeder.sv
// Byte-stream front end for simpleCNN: packs each image row into one wide word,
// presents rows to the classifier one per transfer and holds off the next image until DONE.
module image_row_feeder #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 25,
  parameter int ROWS    = 25
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     PIX_VALID,
  input  logic [PIX_W-1:0]         PIX_DATA,
  output logic                     PIX_READY,
  output logic                     START,
  output logic [4:0]               X,
  output logic [4:0]               Y,
  output logic [PIX_W*ROW_PIX-1:0] IMGIN,
  output logic                     ROW_VALID,
  input  logic                     CNN_DONE,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam int W    = PIX_W * ROW_PIX;
  localparam int PC_W = $clog2(ROW_PIX + 1);

  localparam logic [PC_W-1:0] PC_FULL = PC_W'(ROW_PIX);
  localparam logic [4:0]      RC_LAST = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [4:0]      rc;
  logic [W-1:0]    pack;
  logic            row_full;
  logic            pix_xfer;

  assign row_full  = (pc == PC_FULL);
  assign PIX_READY = !row_full;
  assign pix_xfer  = PIX_VALID && PIX_READY;
  assign BUSY      = (state == STREAM) || (state == WAIT_DONE);

  // Shifting in at the LSB leaves the first pixel of the row in the MSB byte
  // once the row is full, so no per-pixel address decode is needed.
  // NOTE: pack carries no reset; every byte is overwritten before IMGIN loads it,
  // so leaving it out of the reset network keeps the wide datapath plain flops.
  always_ff @(posedge CLK) begin
    if (pix_xfer) begin
      pack <= {pack[W-PIX_W-1:0], PIX_DATA};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values of pc, rc and state regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      pc        <= '0;
      rc        <= '0;
      X         <= '0;
      Y         <= '0;
      IMGIN     <= '0;
      START     <= 1'b0;
      ROW_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      START     <= 1'b0;
      ROW_VALID <= 1'b0;

      // A pixel can never arrive in the same cycle the row drains: ready is low while full.
      if (pix_xfer) begin
        pc <= pc + 1'b1;
      end

      if (CNN_DONE && (state != WAIT_DONE)) begin
        ERR <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (row_full) begin
            START <= 1'b1;
            rc    <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (row_full) begin
            IMGIN     <= pack;
            Y         <= rc;
            ROW_VALID <= 1'b1;
            pc        <= '0;
            rc        <= rc + 5'd1;
            if (rc == RC_LAST) begin
              state <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (CNN_DONE) begin
            X     <= X + 5'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_row_feeder.sv
// Directed bench for image_row_feeder: a counting pixel source, an event log of
// START/ROW_VALID pulses, and one task per scenario comparing against hand-derived values.
module tb_image_row_feeder;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 25;
  localparam int ROWS    = 25;
  localparam int W       = PIX_W * ROW_PIX;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         PIX_VALID;
  logic [7:0]   PIX_DATA;
  logic         PIX_READY;
  logic         START;
  logic [4:0]   X;
  logic [4:0]   Y;
  logic [W-1:0] IMGIN;
  logic         ROW_VALID;
  logic         CNN_DONE;
  logic         BUSY;
  logic         ERR;

  image_row_feeder #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS(ROWS)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
    .PIX_READY(PIX_READY), .START(START), .X(X), .Y(Y), .IMGIN(IMGIN),
    .ROW_VALID(ROW_VALID), .CNN_DONE(CNN_DONE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int         n_vec   = 0;
  int         n_err   = 0;
  int         cyc     = 0;
  int         pix_acc = 0;
  logic [7:0] next_pix = 8'h00;

  int           start_cyc_q[$];
  logic [4:0]   start_x_q[$];
  int           row_cyc_q[$];
  logic [4:0]   row_y_q[$];
  logic [W-1:0] row_data_q[$];

  function automatic logic [W-1:0] mk_row(input logic [7:0] first);
    logic [W-1:0] r;
    logic [7:0]   p;
    r = '0;
    p = first;
    for (int k = 0; k < ROW_PIX; k++) begin
      r[W-1-k*PIX_W -: PIX_W] = p;
      p = p + 8'd1;
    end
    return r;
  endfunction

  // One clock: the handshake is judged before the edge, outputs are sampled 1 after it.
  task automatic tick();
    bit xfer;
    xfer = (PIX_VALID === 1'b1) && (PIX_READY === 1'b1);
    @(posedge CLK);
    #1;
    cyc++;
    if (xfer) begin
      next_pix++;
      pix_acc++;
    end
    PIX_DATA = next_pix;
    if (START === 1'b1) begin
      start_cyc_q.push_back(cyc);
      start_x_q.push_back(X);
    end
    if (ROW_VALID === 1'b1) begin
      row_cyc_q.push_back(cyc);
      row_y_q.push_back(Y);
      row_data_q.push_back(IMGIN);
    end
  endtask

  task automatic clear_log();
    start_cyc_q.delete();
    start_x_q.delete();
    row_cyc_q.delete();
    row_y_q.delete();
    row_data_q.delete();
  endtask

  task automatic wait_rows(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (row_y_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (row_y_q.size() >= n);
  endtask

  task automatic do_reset();
    PIX_VALID = 1'b0;
    CNN_DONE  = 1'b0;
    PIX_DATA  = next_pix;
    nRST      = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    clear_log();
    repeat (3) tick();
    n_vec++;
    if ({START, ROW_VALID, ERR, BUSY, PIX_READY} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 00001 (START ROW_VALID ERR BUSY PIX_READY)",
               {START, ROW_VALID, ERR, BUSY, PIX_READY});
    end
    n_vec++;
    if ({X, Y} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_xy: got X=%0d Y=%0d expected 0 0", X, Y);
    end
    n_vec++;
    if (IMGIN !== '0) begin
      n_err++;
      $display("FAIL reset_imgin: got %h expected 0", IMGIN);
    end
    n_vec++;
    if (start_cyc_q.size() + row_y_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_idle_events: got %0d pulses expected 0", start_cyc_q.size() + row_y_q.size());
    end
  endtask

  task automatic test_single_image();
    bit           ok;
    logic [7:0]   base;
    logic [W-1:0] r0;
    clear_log();
    base = next_pix;
    PIX_VALID = 1'b1;
    wait_rows(ROWS, ROWS * 26 + 40, ok);
    PIX_VALID = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_rows_timeout: got %0d rows expected %0d", row_y_q.size(), ROWS);
    end
    repeat (9) tick();
    n_vec++;
    if ({BUSY, X} !== {1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL single_wait_state: got BUSY=%b X=%0d expected BUSY=1 X=0", BUSY, X);
    end
    CNN_DONE = 1'b1;
    tick();
    CNN_DONE = 1'b0;
    n_vec++;
    if (X !== 5'd1) begin
      n_err++;
      $display("FAIL single_x_advance: got %0d expected 1", X);
    end
    tick();
    n_vec++;
    if ({BUSY, ERR} !== 2'b00) begin
      n_err++;
      $display("FAIL single_idle_after_done: got BUSY=%b ERR=%b expected 0 0", BUSY, ERR);
    end
    n_vec++;
    if (start_cyc_q.size() != 1 || row_y_q.size() != ROWS) begin
      n_err++;
      $display("FAIL single_pulse_counts: got START=%0d ROW_VALID=%0d expected 1 %0d",
               start_cyc_q.size(), row_y_q.size(), ROWS);
    end
    if (start_cyc_q.size() >= 1 && row_y_q.size() >= ROWS) begin
      n_vec++;
      if (start_x_q[0] !== 5'd0 || row_cyc_q[0] != start_cyc_q[0] + 1) begin
        n_err++;
        $display("FAIL single_start: got X=%0d row0_delay=%0d expected X=0 delay=1",
                 start_x_q[0], row_cyc_q[0] - start_cyc_q[0]);
      end
      r0 = row_data_q[0];
      n_vec++;
      if (r0[199:192] !== 8'h00 || r0[7:0] !== 8'h18) begin
        n_err++;
        $display("FAIL single_row0_bytes: got msb=%h lsb=%h expected 00 18", r0[199:192], r0[7:0]);
      end
      for (int i = 0; i < ROWS; i++) begin
        n_vec++;
        if (row_y_q[i] !== 5'(i) || row_data_q[i] !== mk_row(8'(int'(base) + i * ROW_PIX))) begin
          n_err++;
          $display("FAIL single_row%0d: got Y=%0d data=%h expected Y=%0d data=%h",
                   i, row_y_q[i], row_data_q[i], i, mk_row(8'(int'(base) + i * ROW_PIX)));
        end
        if (i > 0) begin
          n_vec++;
          if (row_cyc_q[i] - row_cyc_q[i-1] != ROW_PIX + 1) begin
            n_err++;
            $display("FAIL single_spacing%0d: got %0d cycles expected %0d",
                     i, row_cyc_q[i] - row_cyc_q[i-1], ROW_PIX + 1);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit         ok;
    logic [7:0] base;
    int         acc0;
    int         c_done;
    clear_log();
    base = next_pix;
    PIX_VALID = 1'b1;
    wait_rows(ROWS, ROWS * 26 + 40, ok);
    acc0 = pix_acc;
    repeat (100) tick();
    n_vec++;
    if (!ok || pix_acc - acc0 != ROW_PIX) begin
      n_err++;
      $display("FAIL bp_stall_count: got %0d pixels after last row expected %0d", pix_acc - acc0, ROW_PIX);
    end
    n_vec++;
    if ({PIX_READY, BUSY} !== 2'b01 || start_cyc_q.size() != 1) begin
      n_err++;
      $display("FAIL bp_held_off: got READY=%b BUSY=%b starts=%0d expected 0 1 1",
               PIX_READY, BUSY, start_cyc_q.size());
    end
    c_done = cyc;
    CNN_DONE = 1'b1;
    tick();
    CNN_DONE = 1'b0;
    n_vec++;
    if (X !== 5'd2) begin
      n_err++;
      $display("FAIL bp_x_advance: got %0d expected 2", X);
    end
    wait_rows(ROWS + 2, 80, ok);
    PIX_VALID = 1'b0;
    n_vec++;
    if (!ok || start_cyc_q.size() != 2) begin
      n_err++;
      $display("FAIL bp_next_image: got rows=%0d starts=%0d expected %0d 2",
               row_y_q.size(), start_cyc_q.size(), ROWS + 2);
    end
    if (ok && start_cyc_q.size() == 2) begin
      n_vec++;
      if (start_cyc_q[1] != c_done + 2 || start_x_q[1] !== 5'd2) begin
        n_err++;
        $display("FAIL bp_start_timing: got delay=%0d X=%0d expected delay=2 X=2",
                 start_cyc_q[1] - c_done, start_x_q[1]);
      end
      n_vec++;
      if (row_cyc_q[ROWS] != start_cyc_q[1] + 1 || row_y_q[ROWS] !== 5'd0 ||
          row_data_q[ROWS] !== mk_row(8'(int'(base) + ROWS * ROW_PIX))) begin
        n_err++;
        $display("FAIL bp_row0_stalled: got Y=%0d data=%h expected Y=0 data=%h",
                 row_y_q[ROWS], row_data_q[ROWS], mk_row(8'(int'(base) + ROWS * ROW_PIX)));
      end
      n_vec++;
      if (row_y_q[ROWS+1] !== 5'd1 || row_data_q[ROWS+1] !== mk_row(8'(int'(base) + (ROWS + 1) * ROW_PIX))) begin
        n_err++;
        $display("FAIL bp_row1_resume: got Y=%0d data=%h expected Y=1 data=%h",
                 row_y_q[ROWS+1], row_data_q[ROWS+1], mk_row(8'(int'(base) + (ROWS + 1) * ROW_PIX)));
      end
    end
  endtask

  task automatic test_spurious_done();
    bit         ok;
    int         k;
    logic [7:0] base;
    do_reset();
    clear_log();
    CNN_DONE = 1'b1;
    tick();
    CNN_DONE = 1'b0;
    repeat (5) tick();
    n_vec++;
    if ({ERR, BUSY, X} !== {1'b1, 1'b0, 5'd0}) begin
      n_err++;
      $display("FAIL spur_idle: got ERR=%b BUSY=%b X=%0d expected 1 0 0", ERR, BUSY, X);
    end

    do_reset();
    clear_log();
    tick();
    n_vec++;
    if (ERR !== 1'b0) begin
      n_err++;
      $display("FAIL spur_err_reset: got %b expected 0", ERR);
    end
    base = next_pix;
    PIX_VALID = 1'b1;
    wait_rows(ROWS - 1, ROWS * 26 + 40, ok);
    k = 0;
    while (PIX_READY !== 1'b0 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (!ok || PIX_READY !== 1'b0) begin
      n_err++;
      $display("FAIL spur_last_row_full: got rows=%0d READY=%b expected %0d 0", row_y_q.size(), PIX_READY, ROWS - 1);
    end
    CNN_DONE = 1'b1;
    tick();
    CNN_DONE  = 1'b0;
    PIX_VALID = 1'b0;
    n_vec++;
    if ({ROW_VALID, Y} !== {1'b1, 5'(ROWS - 1)} || IMGIN !== mk_row(8'(int'(base) + (ROWS - 1) * ROW_PIX))) begin
      n_err++;
      $display("FAIL spur_last_row: got ROW_VALID=%b Y=%0d data=%h expected 1 %0d %h",
               ROW_VALID, Y, IMGIN, ROWS - 1, mk_row(8'(int'(base) + (ROWS - 1) * ROW_PIX)));
    end
    n_vec++;
    if ({ERR, BUSY, X} !== {1'b1, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL spur_last_row_done: got ERR=%b BUSY=%b X=%0d expected 1 1 0", ERR, BUSY, X);
    end
    repeat (3) tick();
    CNN_DONE = 1'b1;
    tick();
    CNN_DONE = 1'b0;
    n_vec++;
    if ({ERR, BUSY, X} !== {1'b1, 1'b0, 5'd1}) begin
      n_err++;
      $display("FAIL spur_valid_done: got ERR=%b BUSY=%b X=%0d expected 1 0 1", ERR, BUSY, X);
    end
  endtask

  task automatic test_x_wrap();
    bit         ok;
    bit         all_ok;
    logic [7:0] base;
    int         last;
    do_reset();
    clear_log();
    base   = next_pix;
    all_ok = 1'b1;
    for (int img = 0; img < 33; img++) begin
      PIX_VALID = 1'b1;
      wait_rows(ROWS * (img + 1), ROWS * 26 + 40, ok);
      PIX_VALID = 1'b0;
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
      tick();
      CNN_DONE = 1'b1;
      tick();
      CNN_DONE = 1'b0;
    end
    n_vec++;
    if (!all_ok || start_cyc_q.size() != 33) begin
      n_err++;
      $display("FAIL wrap_counts: got rows=%0d starts=%0d expected %0d 33",
               row_y_q.size(), start_cyc_q.size(), 33 * ROWS);
    end
    n_vec++;
    if (X !== 5'd1) begin
      n_err++;
      $display("FAIL wrap_final_x: got %0d expected 1", X);
    end
    if (all_ok && start_cyc_q.size() == 33) begin
      for (int i = 0; i < 33; i++) begin
        n_vec++;
        if (start_x_q[i] !== 5'(i % 32)) begin
          n_err++;
          $display("FAIL wrap_x%0d: got %0d expected %0d", i, start_x_q[i], i % 32);
        end
      end
      last = 33 * ROWS - 1;
      n_vec++;
      if (row_y_q[last] !== 5'(ROWS - 1) || row_data_q[last] !== mk_row(8'(int'(base) + last * ROW_PIX))) begin
        n_err++;
        $display("FAIL wrap_last_row: got Y=%0d data=%h expected Y=%0d data=%h",
                 row_y_q[last], row_data_q[last], ROWS - 1, mk_row(8'(int'(base) + last * ROW_PIX)));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit         ok;
    int         k;
    int         acc0;
    logic [7:0] base;
    clear_log();
    PIX_VALID = 1'b1;
    wait_rows(3, 4 * 26 + 40, ok);
    acc0 = pix_acc;
    k = 0;
    while (pix_acc < acc0 + 12 && k < 40) begin
      tick();
      k++;
    end
    n_vec++;
    if (!ok || pix_acc != acc0 + 12 || X !== 5'd1) begin
      n_err++;
      $display("FAIL mid_setup: got rows=%0d pixels=%0d X=%0d expected 3 12 1", row_y_q.size(), pix_acc - acc0, X);
    end
    PIX_VALID = 1'b0;
    nRST = 1'b0;
    #1;
    n_vec++;
    if ({START, ROW_VALID, BUSY, ERR} !== 4'b0000 || {X, Y} !== 10'd0) begin
      n_err++;
      $display("FAIL mid_async_clear: got flags=%b X=%0d Y=%0d expected 0000 0 0",
               {START, ROW_VALID, BUSY, ERR}, X, Y);
    end
    n_vec++;
    if (IMGIN !== '0) begin
      n_err++;
      $display("FAIL mid_async_imgin: got %h expected 0", IMGIN);
    end
    @(negedge CLK);
    nRST = 1'b1;
    PIX_DATA = next_pix;
    base = next_pix;
    clear_log();
    n_vec++;
    if (PIX_READY !== 1'b1) begin
      n_err++;
      $display("FAIL mid_ready_release: got %b expected 1", PIX_READY);
    end
    PIX_VALID = 1'b1;
    wait_rows(1, 60, ok);
    PIX_VALID = 1'b0;
    n_vec++;
    if (!ok || start_cyc_q.size() != 1) begin
      n_err++;
      $display("FAIL mid_restart: got rows=%0d starts=%0d expected 1 1", row_y_q.size(), start_cyc_q.size());
    end
    if (ok && start_cyc_q.size() == 1) begin
      n_vec++;
      if (start_x_q[0] !== 5'd0 || row_y_q[0] !== 5'd0 || row_cyc_q[0] != start_cyc_q[0] + 1 ||
          row_data_q[0] !== mk_row(base)) begin
        n_err++;
        $display("FAIL mid_row0: got X=%0d Y=%0d data=%h expected X=0 Y=0 data=%h",
                 start_x_q[0], row_y_q[0], row_data_q[0], mk_row(base));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_image();
    test_backpressure();
    test_spurious_done();
    test_x_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
